// File: rtl/telemetry_tx_if.sv
// Sample-bus and status bundle between the data collector and the telemetry serialiser.
interface telemetry_tx_if;
   logic       sample_valid;
   logic [7:0] sample_data;
   logic       ovf_clr;
   logic       tx;
   logic       busy;
   logic [4:0] fifo_count;
   logic       overflow;

   modport master (
      output sample_valid, sample_data, ovf_clr,
      input  tx, busy, fifo_count, overflow
   );

   modport slave (
      input  sample_valid, sample_data, ovf_clr,
      output tx, busy, fifo_count, overflow
   );
endinterface

// File: rtl/telemetry_tx.sv
// Buffers 8-bit voltage samples in a small FIFO and serialises them as 8N1 frames,
// sending back-to-back frames with no idle gap while samples are waiting.
module telemetry_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   telemetry_tx_if.slave bus
);
   localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int             AW       = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0]  BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [4:0]     DEPTH5   = 5'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

   state_t         state_r, state_s;
   logic [CW-1:0]  clk_cnt_r;
   logic [2:0]     bit_idx_r;
   logic [7:0]     shift_r;
   logic           tx_r, busy_r, overflow_r;
   logic [7:0]     mem_r [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
   logic [4:0]     count_r;
   logic           bit_end_s, pop_s, push_s, drop_s, fifo_nonempty_s;

   assign bit_end_s       = (clk_cnt_r == BIT_LAST);
   assign fifo_nonempty_s = (count_r != 5'd0);
   // A full FIFO still takes a write when the same edge pops the oldest entry.
   assign push_s          = bus.sample_valid && ((count_r < DEPTH5) || pop_s);
   assign drop_s          = bus.sample_valid && !push_s;

   assign bus.tx         = tx_r;
   assign bus.busy       = busy_r;
   assign bus.fifo_count = count_r;
   assign bus.overflow   = overflow_r;

   // Next-state and pop decode
   always_comb begin
      state_s = state_r;
      pop_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (fifo_nonempty_s) begin
               state_s = START;
               pop_s   = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            if (bit_end_s) state_s = DATA;
            else           state_s = START;
         end
         DATA: begin
            if (bit_end_s && (bit_idx_r == 3'd7)) state_s = STOP;
            else                                  state_s = DATA;
         end
         STOP: begin
            if (bit_end_s && fifo_nonempty_s) begin
               state_s = START;
               pop_s   = 1'b1;
            end else if (bit_end_s) begin
               state_s = IDLE;
            end else begin
               state_s = STOP;
            end
         end
         default: begin
            state_s = IDLE;
            pop_s   = 1'b0;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state_r <= IDLE;
      else       state_r <= state_s;
   end

   // Bit timing, shift register and registered serial line
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         clk_cnt_r <= '0;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'h00;
         tx_r      <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         busy_r <= (state_s != IDLE);
         if ((state_r == IDLE) || bit_end_s) clk_cnt_r <= '0;
         else                                clk_cnt_r <= clk_cnt_r + CW'(1);

         if (pop_s) begin
            shift_r   <= mem_r[rd_ptr_r];
            tx_r      <= 1'b0;
            bit_idx_r <= 3'd0;
         end else if (bit_end_s && (state_r == START)) begin
            tx_r    <= shift_r[0];
            shift_r <= {1'b0, shift_r[7:1]};
         end else if (bit_end_s && (state_r == DATA)) begin
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
               tx_r <= 1'b1;
            end else begin
               tx_r    <= shift_r[0];
               shift_r <= {1'b0, shift_r[7:1]};
            end
         end else if (state_s == IDLE) begin
            tx_r <= 1'b1;
         end
      end
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= 5'd0;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 5'd1;
            2'b01:   count_r <= count_r - 5'd1;
            default: count_r <= count_r;
         endcase
         // A new drop wins over a same-edge clear.
         if (drop_s)           overflow_r <= 1'b1;
         else if (bus.ovf_clr) overflow_r <= 1'b0;
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push_s && !rst_n) mem_r[wr_ptr_r] <= bus.sample_data;
   end
endmodule

// File: tb/tb_telemetry_tx.sv
// Self-checking bench for telemetry_tx: directed frame/overflow/reset sequences plus
// randomized traffic compared every cycle against a queue-based frame model.
module tb_telemetry_tx;
   localparam int CPB   = 16;
   localparam int DEPTH = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   telemetry_tx_if bus ();

   telemetry_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: queue of waiting bytes plus elapsed time inside the current frame.
   logic [7:0] mq[$];
   bit         m_active;
   int         m_t;
   logic [7:0] m_cur;
   bit         m_ovf;

   bit   rec_on = 1'b0;
   logic txq[$];

   typedef struct {
      logic       v;
      logic       clr;
      logic [4:0] cnt;
      logic       ovf;
      logic       busy;
   } vec_t;
   vec_t tbl[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic m_tx();
      int k;
      if (!m_active) return 1'b1;
      k = m_t / CPB;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return m_cur[k-1];
   endfunction

   task automatic model_reset();
      mq.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_cur    = 8'h00;
      m_ovf    = 1'b0;
   endtask

   task automatic model_edge(input logic v, input logic [7:0] d, input logic clr);
      bit frame_end, pop, accept;
      frame_end = m_active && (m_t == 10*CPB - 1);
      pop       = (!m_active || frame_end) && (mq.size() > 0);
      accept    = v && ((mq.size() < DEPTH) || pop);
      if (pop) begin
         m_cur    = mq.pop_front();
         m_active = 1'b1;
         m_t      = 0;
      end else if (frame_end) begin
         m_active = 1'b0;
      end else if (m_active) begin
         m_t++;
      end
      if (accept) mq.push_back(d);
      if (v && !accept) m_ovf = 1'b1;
      else if (clr)     m_ovf = 1'b0;
   endtask

   // One clock: drive inputs, advance the model on the edge, compare on the falling edge.
   task automatic step(input logic v, input logic [7:0] d, input logic clr);
      bus.sample_valid = v;
      bus.sample_data  = d;
      bus.ovf_clr      = clr;
      @(posedge clk);
      model_edge(v, d, clr);
      @(negedge clk);
      check("model_tx",       32'(bus.tx),         32'(m_tx()));
      check("model_busy",     32'(bus.busy),       32'(m_active));
      check("model_count",    32'(bus.fifo_count), 32'(mq.size()));
      check("model_overflow", 32'(bus.overflow),   32'(m_ovf));
      if (rec_on) txq.push_back(bus.tx);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic do_reset();
      bus.sample_valid = 1'b0;
      bus.sample_data  = 8'h00;
      bus.ovf_clr      = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx",       32'(bus.tx),         32'd1);
      check("rst_busy",     32'(bus.busy),       32'd0);
      check("rst_count",    32'(bus.fifo_count), 32'd0);
      check("rst_overflow", 32'(bus.overflow),   32'd0);
      model_reset();
      rst_n = 1'b0;
   endtask

   // line[k] is the required tx level during bit period k of the frame.
   task automatic single_frame(input string name, input logic [7:0] b, input logic [9:0] line);
      step(1'b1, b, 1'b0);
      check({name, "_tx_e"},   32'(bus.tx),   32'd1);
      check({name, "_busy_e"}, 32'(bus.busy), 32'd0);
      for (int c = 0; c < 10*CPB; c++) begin
         step(1'b0, 8'h00, 1'b0);
         check({name, "_tx"},   32'(bus.tx),   32'(line[c/CPB]));
         check({name, "_busy"}, 32'(bus.busy), 32'd1);
      end
      step(1'b0, 8'h00, 1'b0);
      check({name, "_tx_end"},   32'(bus.tx),   32'd1);
      check({name, "_busy_end"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] got[$];
      int         idx;
      logic [7:0] b;
      logic       v, clr;

      // Overflow / ovf_clr table: ten writes from idle, then clear cases.
      for (int i = 0; i < 13; i++) begin
         tbl[i].v    = (i <= 10) ? 1'b1 : 1'b0;
         tbl[i].clr  = (i == 10 || i == 11) ? 1'b1 : 1'b0;
         tbl[i].busy = (i == 0) ? 1'b0 : 1'b1;
         tbl[i].ovf  = (i == 9 || i == 10) ? 1'b1 : 1'b0;
      end
      tbl[0].cnt = 5'd1; tbl[1].cnt = 5'd1; tbl[2].cnt = 5'd2; tbl[3].cnt = 5'd3;
      tbl[4].cnt = 5'd4; tbl[5].cnt = 5'd5; tbl[6].cnt = 5'd6; tbl[7].cnt = 5'd7;
      for (int i = 8; i < 13; i++) tbl[i].cnt = 5'd8;

      do_reset();
      idle(3);

      single_frame("a5", 8'hA5, 10'b1101001010);

      // Three consecutive samples: contiguous frames, count 1,1,2 then decrementing.
      step(1'b1, 8'h01, 1'b0); check("b2b_cnt0", 32'(bus.fifo_count), 32'd1);
      step(1'b1, 8'h02, 1'b0); check("b2b_cnt1", 32'(bus.fifo_count), 32'd1);
      step(1'b1, 8'h03, 1'b0); check("b2b_cnt2", 32'(bus.fifo_count), 32'd2);
      for (int k = 3; k <= 481; k++) begin
         step(1'b0, 8'h00, 1'b0);
         if (k == 161) check("b2b_cnt_f2", 32'(bus.fifo_count), 32'd1);
         if (k == 321) check("b2b_cnt_f3", 32'(bus.fifo_count), 32'd0);
         if (k < 481)  check("b2b_busy",   32'(bus.busy),       32'd1);
         else          check("b2b_idle",   32'(bus.busy),       32'd0);
      end

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].v, 8'(i + 16), tbl[i].clr);
         check("tbl_count",    32'(bus.fifo_count), 32'(tbl[i].cnt));
         check("tbl_overflow", 32'(bus.overflow),   32'(tbl[i].ovf));
         check("tbl_busy",     32'(bus.busy),       32'(tbl[i].busy));
      end

      // Asynchronous reset during data bit 3 with four samples queued.
      do_reset();
      idle(2);
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
      idle(66);
      check("mid_cnt_before", 32'(bus.fifo_count), 32'd4);
      #2 rst_n = 1'b1;
      #1;
      check("mid_rst_tx",    32'(bus.tx),         32'd1);
      check("mid_rst_busy",  32'(bus.busy),       32'd0);
      check("mid_rst_count", 32'(bus.fifo_count), 32'd0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      idle(20);
      single_frame("x3c", 8'h3C, 10'b1001111000);

      // Twenty samples, one per frame time, decoded independently from the line.
      rec_on = 1'b1;
      for (int s = 0; s < 20; s++) begin
         step(1'b1, 8'(8'h40 + s), 1'b0);
         idle(10*CPB - 1);
      end
      idle(200);
      rec_on = 1'b0;
      check("stream_overflow", 32'(bus.overflow),   32'd0);
      check("stream_count",    32'(bus.fifo_count), 32'd0);
      idx = 0;
      while (idx + 10*CPB <= txq.size()) begin
         if (txq[idx] == 1'b0) begin
            for (int k = 0; k < 8; k++) b[k] = txq[idx + CPB/2 + CPB*(k+1)];
            check("stream_stop", 32'(txq[idx + CPB/2 + CPB*9]), 32'd1);
            got.push_back(b);
            idx += 10*CPB;
         end else begin
            idx++;
         end
      end
      check("stream_frames", 32'(got.size()), 32'd20);
      for (int s = 0; s < 20 && s < got.size(); s++)
         check("stream_byte", 32'(got[s]), 32'(8'h40 + s));

      // Randomized traffic: heavy load (fills and overflows), then a trickle (drains).
      do_reset();
      for (int i = 0; i < 6000; i++) begin
         if (i < 2500) v = ($urandom_range(0, 9) < 3);
         else          v = ($urandom_range(0, 199) == 0);
         clr = ($urandom_range(0, 31) == 0);
         step(v, 8'($urandom), clr);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
